// File: rtl/rtc_lectura_seq_if.sv
// RTC register-bus read port: request/acknowledge handshake plus address and data.
// The sequencer drives the master side; the RTC bus (or a bench model) the slave side.
interface rtc_lectura_seq_if;
    logic       rd_req;
    logic [3:0] dir;
    logic       rd_ack;
    logic [7:0] rd_data;

    modport master (output rd_req, output dir, input rd_ack, input rd_data);
    modport slave  (input rd_req, input dir, output rd_ack, output rd_data);
endinterface

// File: rtl/rtc_lectura_seq.sv
// rtc_lectura_seq: read-side sweeper for the RTC register bus.
// On a start tick (while enabled) it reads dir 0..LAST with a req/ack handshake,
// masks each BCD byte, keeps it only if both nibbles are decimal, and pulses
// frame_valid once the whole map has been read.
// Build option: define RTC_TIMER_READ_EN to extend the sweep to the timer
// registers (dir 6..8, LAST=8); otherwise LAST=5 and the timer fields stay 8'h00.
module rtc_lectura_seq #(
    parameter logic [7:0] TIMEOUT_CYC = 8'd200,  // cycles to wait for rd_ack before giving up
    parameter logic [1:0] GAP_CYC     = 2'd1     // idle cycles between reads, must be >= 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     enable,
    rtc_lectura_seq_if.master        bus,
    output logic                     busy,
    output logic                     frame_valid,
    output logic                     err,
    output logic [7:0]               horar,
    output logic [7:0]               minr,
    output logic [7:0]               segr,
    output logic [7:0]               diar,
    output logic [7:0]               mesr,
    output logic [7:0]               annor,
    output logic [7:0]               thorar,
    output logic [7:0]               tminr,
    output logic [7:0]               tsegr
);

`ifdef RTC_TIMER_READ_EN
    localparam int LAST_IDX = 8;
`else
    localparam int LAST_IDX = 5;
`endif
    localparam logic [3:0] LAST_DIR = 4'(LAST_IDX);
    localparam int N_FIELDS = 9;

    typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

    state_t     state_reg;
    logic [7:0] tout_cnt_reg;
    logic [1:0] gap_cnt_reg;
    logic       rd_req_reg;
    logic [3:0] dir_reg;
    logic       busy_reg;
    logic       frame_valid_reg;
    logic       err_reg;
    logic [7:0] field_reg [N_FIELDS];

    logic [7:0] cap_mask;
    logic [7:0] cap_data;
    logic       cap_bcd_ok;
    logic       cap_we;

    // Capture path: per-address mask, BCD validity and field write strobe.
    always_comb begin
        cap_mask = 8'h00;
        case (dir_reg)
            4'd0:    cap_mask = 8'h3F;
            4'd1:    cap_mask = 8'h7F;
            4'd2:    cap_mask = 8'h7F;
            4'd3:    cap_mask = 8'h3F;
            4'd4:    cap_mask = 8'h1F;
            4'd5:    cap_mask = 8'hFF;
            4'd6:    cap_mask = 8'h3F;
            4'd7:    cap_mask = 8'h7F;
            4'd8:    cap_mask = 8'h7F;
            default: cap_mask = 8'h00;
        endcase
        cap_data   = bus.rd_data & cap_mask;
        cap_bcd_ok = (cap_data[7:4] <= 4'd9) && (cap_data[3:0] <= 4'd9);
        cap_we     = (state_reg == REQ) && bus.rd_ack && cap_bcd_ok;
    end

    // Sweep FSM: every handshake/status output is a register updated here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            tout_cnt_reg    <= 8'd0;
            gap_cnt_reg     <= 2'd0;
            rd_req_reg      <= 1'b0;
            dir_reg         <= 4'd0;
            busy_reg        <= 1'b0;
            frame_valid_reg <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            frame_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // start is a one-shot: if it arrives while disabled it is simply lost
                    if (start && enable) begin
                        state_reg    <= REQ;
                        dir_reg      <= 4'd0;
                        err_reg      <= 1'b0;
                        busy_reg     <= 1'b1;
                        rd_req_reg   <= 1'b1;
                        tout_cnt_reg <= 8'd0;
                    end
                end
                REQ: begin
                    // ack is tested first so an ack on the last allowed cycle still counts
                    if (bus.rd_ack) begin
                        rd_req_reg  <= 1'b0;
                        gap_cnt_reg <= 2'd0;
                        state_reg   <= GAP;
                        if (!cap_bcd_ok) begin
                            err_reg <= 1'b1;
                        end
                    end else if (tout_cnt_reg == TIMEOUT_CYC - 8'd1) begin
                        rd_req_reg  <= 1'b0;
                        gap_cnt_reg <= 2'd0;
                        err_reg     <= 1'b1;
                        state_reg   <= GAP;
                    end else begin
                        tout_cnt_reg <= tout_cnt_reg + 8'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt_reg != GAP_CYC - 2'd1) begin
                        gap_cnt_reg <= gap_cnt_reg + 2'd1;
                    end else if (!enable) begin
                        // master left run mode: drop the frame, keep what was captured
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (dir_reg == LAST_DIR) begin
                        state_reg <= DONE;
                    end else begin
                        dir_reg      <= dir_reg + 4'd1;
                        rd_req_reg   <= 1'b1;
                        tout_cnt_reg <= 8'd0;
                        state_reg    <= REQ;
                    end
                end
                DONE: begin
                    frame_valid_reg <= 1'b1;
                    busy_reg        <= 1'b0;
                    state_reg       <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // One holding register per address; fields beyond LAST never load.
    for (genvar gi = 0; gi < N_FIELDS; gi++) begin : g_field
        localparam logic [7:0] RST_VAL = (gi == 3 || gi == 4) ? 8'h01 : 8'h00;
        localparam bit         ACTIVE  = (gi <= LAST_IDX);

        // Load the masked byte only on an accepted capture at this address.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                field_reg[gi] <= RST_VAL;
            end else if (ACTIVE && cap_we && (dir_reg == 4'(gi))) begin
                field_reg[gi] <= cap_data;
            end
        end
    end

    assign bus.rd_req  = rd_req_reg;
    assign bus.dir     = dir_reg;
    assign busy        = busy_reg;
    assign frame_valid = frame_valid_reg;
    assign err         = err_reg;
    assign horar       = field_reg[0];
    assign minr        = field_reg[1];
    assign segr        = field_reg[2];
    assign diar        = field_reg[3];
    assign mesr        = field_reg[4];
    assign annor       = field_reg[5];
    assign thorar      = field_reg[6];
    assign tminr       = field_reg[7];
    assign tsegr       = field_reg[8];

endmodule

// File: tb/tb_rtc_lectura_seq.sv
// Self-checking bench for rtc_lectura_seq: a table of directed sweeps, an
// enable-abort sweep, random sweeps and a reset-mid-sweep sequence, all checked
// against a sweep-level reference model (fields, err, frame_valid timing).
module tb_rtc_lectura_seq;

`ifdef RTC_TIMER_READ_EN
    localparam int LAST = 8;
    localparam int ZW_CYC = 19;  // edges after the start edge (20 counting the start edge)
`else
    localparam int LAST = 5;
    localparam int ZW_CYC = 13;
`endif
    localparam int TOUT = 200;
    localparam int GAP  = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic enable = 1'b1;
    logic busy, frame_valid, err;
    logic [7:0] horar, minr, segr, diar, mesr, annor, thorar, tminr, tsegr;

    rtc_lectura_seq_if bus ();

    rtc_lectura_seq dut (
        .clk(clk), .reset(reset), .start(start), .enable(enable), .bus(bus),
        .busy(busy), .frame_valid(frame_valid), .err(err),
        .horar(horar), .minr(minr), .segr(segr), .diar(diar), .mesr(mesr),
        .annor(annor), .thorar(thorar), .tminr(tminr), .tsegr(tsegr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] m_field [9];
    bit         m_err;

    typedef struct packed {
        logic [8:0][7:0] data;
        logic [8:0][7:0] dly;    // ack on this REQ cycle (1-based); 0 = never ack
        bit              restart;
        logic [5:0][7:0] exp_f;
        bit              exp_err;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mask_of(input int k);
        logic [7:0] m;
        case (k)
            0, 3, 6: m = 8'h3F;
            1, 2, 7, 8: m = 8'h7F;
            4: m = 8'h1F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] dut_field(input int k);
        logic [7:0] v;
        case (k)
            0: v = horar;  1: v = minr;   2: v = segr;
            3: v = diar;   4: v = mesr;   5: v = annor;
            6: v = thorar; 7: v = tminr;  default: v = tsegr;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 9; k++) m_field[k] = (k == 3 || k == 4) ? 8'h01 : 8'h00;
        m_err = 1'b0;
    endtask

    // Reference: per address it costs its ack delay (or the full timeout) plus the gap.
    task automatic model_sweep(input logic [8:0][7:0] data, input logic [8:0][7:0] dly,
                               input int abort_dir, output int exp_cyc);
        int cyc;
        int d;
        int v;
        cyc = 0;
        exp_cyc = -1;
        m_err = 1'b0;
        for (int k = 0; k <= LAST; k++) begin
            d = int'(dly[k]);
            if (d == 0 || d > TOUT) begin
                cyc += TOUT;
                m_err = 1'b1;
            end else begin
                cyc += d;
                v = int'(data[k] & mask_of(k));
                if (v / 16 <= 9 && v % 16 <= 9) m_field[k] = 8'(v);
                else m_err = 1'b1;
            end
            cyc += GAP;
            if (k == abort_dir) return;
        end
        exp_cyc = cyc + 1;
    endtask

    // Plays the RTC bus slave for one sweep and measures the frame_valid edge.
    task automatic run_sweep(input logic [8:0][7:0] data, input logic [8:0][7:0] dly,
                             input bit restart, input int abort_dir,
                             output int fv_cyc, output int fv_count);
        int cyc;
        int req_cnt;
        int cur;
        fv_cyc = -1;
        fv_count = 0;
        req_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 4000) begin
            @(negedge clk);
            if (frame_valid) begin
                fv_count++;
                if (fv_cyc < 0) fv_cyc = cyc;
            end
            if (!busy) break;
            start = restart && (cyc == 5);
            if (bus.rd_req) begin
                req_cnt++;
                cur = int'(bus.dir);
                if (cur == abort_dir) enable = 1'b0;
                if (cur < 9 && dly[cur] != 8'd0 && req_cnt == int'(dly[cur])) begin
                    bus.rd_ack = 1'b1;
                    bus.rd_data = data[cur];
                end else begin
                    bus.rd_ack = 1'b0;
                    bus.rd_data = 8'($urandom);
                end
            end else begin
                // acks outside a request must be ignored
                req_cnt = 0;
                bus.rd_ack = 1'($urandom_range(0, 1));
                bus.rd_data = 8'($urandom);
            end
            @(posedge clk);
            cyc++;
        end
        chk("sweep_bound", int'(cyc < 4000), 1);
        bus.rd_ack = 1'b0;
        start = 1'b0;
        @(negedge clk);
        if (frame_valid) fv_count++;
        chk("idle_after_sweep", int'(busy), 0);
        enable = 1'b1;
    endtask

    task automatic check_sweep(input string tag, input int exp_cyc, input int fv_cyc, input int fv_count);
        chk({tag, "_fv_cycle"}, fv_cyc, exp_cyc);
        chk({tag, "_fv_pulses"}, fv_count, (exp_cyc < 0) ? 0 : 1);
        chk({tag, "_err"}, int'(err), int'(m_err));
        for (int k = 0; k < 9; k++) chk($sformatf("%s_field%0d", tag, k), int'(dut_field(k)), int'(m_field[k]));
    endtask

    initial begin
        int exp_cyc, fv_cyc, fv_count, guard;
        logic [8:0][7:0] rdata, rdly;

        bus.rd_ack = 1'b0;
        bus.rd_data = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rd_req", int'(bus.rd_req), 0);
        chk("rst_dir", int'(bus.dir), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fv", int'(frame_valid), 0);
        chk("rst_err", int'(err), 0);
        for (int k = 0; k < 9; k++) chk($sformatf("rst_field%0d", k), int'(dut_field(k)), int'(m_field[k]));

        // zero-wait sweep
        vecs[0].data    = {8'h03, 8'h02, 8'h01, 8'h16, 8'h09, 8'h15, 8'h56, 8'h34, 8'h12};
        vecs[0].dly     = {9{8'd1}};
        vecs[0].restart = 1'b0;
        vecs[0].exp_f   = {8'h16, 8'h09, 8'h15, 8'h56, 8'h34, 8'h12};
        vecs[0].exp_err = 1'b0;
        // masking (D2 -> 12) and non-BCD rejection (5C), plus a start while busy
        vecs[1].data    = {8'h33, 8'h22, 8'h11, 8'h99, 8'h12, 8'h21, 8'h07, 8'h5C, 8'hD2};
        vecs[1].dly     = {8'd1, 8'd2, 8'd1, 8'd3, 8'd1, 8'd2, 8'd1, 8'd1, 8'd1};
        vecs[1].restart = 1'b1;
        vecs[1].exp_f   = {8'h99, 8'h12, 8'h21, 8'h07, 8'h34, 8'h12};
        vecs[1].exp_err = 1'b1;
        // no ack at dir 4: timeout, mesr keeps its value, sweep continues
        vecs[2].data    = {8'h45, 8'h44, 8'h43, 8'h05, 8'h06, 8'h04, 8'h03, 8'h02, 8'h01};
        vecs[2].dly     = {8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd3, 8'd2, 8'd1};
        vecs[2].restart = 1'b0;
        vecs[2].exp_f   = {8'h05, 8'h12, 8'h04, 8'h03, 8'h02, 8'h01};
        vecs[2].exp_err = 1'b1;
        // ack on the very last timeout cycle wins
        vecs[3].data    = {8'h30, 8'h20, 8'h10, 8'h20, 8'h07, 8'h11, 8'h10, 8'h09, 8'h08};
        vecs[3].dly     = {8'd1, 8'd1, 8'd1, 8'd1, 8'd200, 8'd1, 8'd1, 8'd1, 8'd1};
        vecs[3].restart = 1'b0;
        vecs[3].exp_f   = {8'h20, 8'h07, 8'h11, 8'h10, 8'h09, 8'h08};
        vecs[3].exp_err = 1'b0;

        for (int i = 0; i < 4; i++) begin
            model_sweep(vecs[i].data, vecs[i].dly, -1, exp_cyc);
            run_sweep(vecs[i].data, vecs[i].dly, vecs[i].restart, -1, fv_cyc, fv_count);
            $display("vec %0d: fv_cycle=%0d pulses=%0d err=%0b", i, fv_cyc, fv_count, err);
            check_sweep($sformatf("vec%0d", i), exp_cyc, fv_cyc, fv_count);
            for (int k = 0; k < 6; k++)
                chk($sformatf("vec%0d_tbl_field%0d", i, k), int'(dut_field(k)), int'(vecs[i].exp_f[k]));
            chk($sformatf("vec%0d_tbl_err", i), int'(err), int'(vecs[i].exp_err));
            if (i == 0) chk("zero_wait_latency", fv_cyc, ZW_CYC);
        end

        // enable drops during dir 2: read finishes, then abort with no frame
        rdata = {8'h59, 8'h58, 8'h57, 8'h56, 8'h55, 8'h04, 8'h23, 8'h45, 8'h21};
        rdly  = {9{8'd1}};
        model_sweep(rdata, rdly, 2, exp_cyc);
        run_sweep(rdata, rdly, 1'b0, 2, fv_cyc, fv_count);
        $display("abort: fv_cycle=%0d pulses=%0d", fv_cyc, fv_count);
        check_sweep("abort", exp_cyc, fv_cyc, fv_count);

        // random sweeps against the model
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 9; k++) begin
                if ($urandom_range(0, 1) == 1)
                    rdata[k] = 8'(($urandom_range(0, 9) << 4) | $urandom_range(0, 9)) & mask_of(k);
                else
                    rdata[k] = 8'($urandom);
                rdly[k] = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
            end
            model_sweep(rdata, rdly, -1, exp_cyc);
            run_sweep(rdata, rdly, 1'($urandom_range(0, 1)), -1, fv_cyc, fv_count);
            $display("rand %0d: fv_cycle=%0d pulses=%0d err=%0b", r, fv_cyc, fv_count, err);
            check_sweep($sformatf("rand%0d", r), exp_cyc, fv_cyc, fv_count);
        end

        // reset while rd_req is high at dir 3
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        guard = 0;
        while (guard < 100) begin
            @(negedge clk);
            if (bus.rd_req && bus.dir == 4'd3) break;
            bus.rd_ack = bus.rd_req;
            bus.rd_data = 8'h11;
            guard++;
        end
        chk("rst_mid_reach_dir3", int'(guard < 100), 1);
        bus.rd_ack = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_mid_rd_req", int'(bus.rd_req), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_dir", int'(bus.dir), 0);
        chk("rst_mid_err", int'(err), 0);
        for (int k = 0; k < 9; k++) chk($sformatf("rst_mid_field%0d", k), int'(dut_field(k)), int'(m_field[k]));
        $display("reset mid-sweep: rd_req=%0b busy=%0b diar=%0h mesr=%0h", bus.rd_req, busy, diar, mesr);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
